// File: rtl/load_store_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_queue_if
// Purpose  : Bundle of every handshake/bus signal of the load/store queue:
//            global stall, dispatch, CDB snoop, ROB commit/flush, store-ready
//            report, memory controller request/response and CDB result.
// Ports    : master modport = environment (dispatch, ROB, CDB, MemCtrl side)
//            slave  modport = load_store_queue
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              rdy;
    logic              disp_en;
    logic [3:0]        disp_op;
    logic [DATA_W-1:0] disp_imm;
    logic              disp_rs1_rdy;
    logic              disp_rs2_rdy;
    logic [DATA_W-1:0] disp_rs1_val;
    logic [DATA_W-1:0] disp_rs2_val;
    logic [TAG_W-1:0]  disp_rs1_tag;
    logic [TAG_W-1:0]  disp_rs2_tag;
    logic [TAG_W-1:0]  disp_dest_tag;
    logic              lsq_full;
    logic              cdb_in_valid;
    logic [TAG_W-1:0]  cdb_in_tag;
    logic [DATA_W-1:0] cdb_in_data;
    logic              commit_store;
    logic              flush;
    logic              st_rdy_valid;
    logic [TAG_W-1:0]  st_rdy_tag;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_len;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    modport master (
        output rdy, disp_en, disp_op, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag,
               disp_dest_tag, cdb_in_valid, cdb_in_tag, cdb_in_data,
               commit_store, flush, mem_valid, mem_rdata,
        input  lsq_full, st_rdy_valid, st_rdy_tag, mem_req, mem_we, mem_addr,
               mem_len, mem_wdata, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  rdy, disp_en, disp_op, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag,
               disp_dest_tag, cdb_in_valid, cdb_in_tag, cdb_in_data,
               commit_store, flush, mem_valid, mem_rdata,
        output lsq_full, st_rdy_valid, st_rdy_tag, mem_req, mem_we, mem_addr,
               mem_len, mem_wdata, cdb_valid, cdb_tag, cdb_data
    );
endinterface
`default_nettype wire

// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : load_store_queue
// Purpose  : In-order circular load/store queue. Operands wake up by snooping
//            the CDB, addresses are computed per entry, stores wait for ROB
//            commit, and one memory request is outstanding at a time. A flush
//            keeps only committed stores.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - load_store_queue_if.slave (dispatch, CDB, ROB, MemCtrl)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    load_store_queue_if.slave bus
);
    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w+1)'(DEPTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    // Per-entry storage
    logic [3:0]        r_op      [DEPTH];
    logic [DATA_W-1:0] r_imm     [DEPTH];
    logic [DATA_W-1:0] r_rs1_val [DEPTH];
    logic [DATA_W-1:0] r_rs2_val [DEPTH];
    logic [TAG_W-1:0]  r_rs1_tag [DEPTH];
    logic [TAG_W-1:0]  r_rs2_tag [DEPTH];
    logic [TAG_W-1:0]  r_dest    [DEPTH];
    logic [ADDR_W-1:0] r_addr    [DEPTH];
    logic [DEPTH-1:0]  r_rs1_rdy, r_rs2_rdy, r_addr_rdy, r_committed, r_reported;

    logic [c_ptr_w-1:0] r_head, r_tail;
    logic [c_ptr_w:0]   r_count;
    state_t             r_state;
    logic               r_squash;     // in-flight load was flushed; discard its response
    logic               r_pend;       // mem_valid seen during a stall
    logic [DATA_W-1:0]  r_pend_data;

    logic              r_mem_req, r_mem_we, r_cdb_valid, r_st_rdy_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_mem_len;
    logic [DATA_W-1:0] r_mem_wdata, r_cdb_data;
    logic [TAG_W-1:0]  r_cdb_tag, r_st_rdy_tag;

    // Combinational helpers
    logic [DEPTH-1:0]   w_is_store, w_elig, w_valid, w_comm_next;
    logic [c_ptr_w-1:0] w_idx, w_commit_idx, w_rep_idx, w_nh, w_iss_idx, w_new_head;
    logic               w_commit_hit, w_rep_hit;
    logic [c_ptr_w:0]   w_n_comm;
    logic               w_done, w_retire, w_squash_now, w_pop_head, w_cdb_fire;
    logic               w_disp_ok, w_issue_idle, w_nh_ok;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_rs1_fwd, w_rs2_fwd;

    function automatic logic [2:0] f_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_wdata(input logic [1:0] sz, input logic [DATA_W-1:0] v);
        case (sz)
            2'b00:   return {{(DATA_W-8){1'b0}}, v[7:0]};
            2'b01:   return {{(DATA_W-16){1'b0}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_load(input logic [2:0] f3, input logic [DATA_W-1:0] d);
        case (f3)
            3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};
            3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};
            3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]};
            3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_is_store[i] = r_op[i][3];
        end
    end

    // Loads need only an address; stores additionally need data and commit.
    assign w_elig = r_addr_rdy & (~w_is_store | (r_rs2_rdy & r_committed));

    // Oldest-first scans over the occupied window starting at head.
    always_comb begin
        w_valid      = '0;
        w_idx        = '0;
        w_commit_hit = 1'b0;
        w_commit_idx = '0;
        w_rep_hit    = 1'b0;
        w_rep_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_ptr_w'(i);
            if ({1'b0, c_ptr_w'(i)} < r_count) begin
                w_valid[w_idx] = 1'b1;
                if (!w_commit_hit && w_is_store[w_idx] && !r_committed[w_idx]) begin
                    w_commit_hit = 1'b1;
                    w_commit_idx = w_idx;
                end
                if (!w_rep_hit && w_is_store[w_idx] && r_addr_rdy[w_idx] &&
                    r_rs2_rdy[w_idx] && !r_reported[w_idx]) begin
                    w_rep_hit = 1'b1;
                    w_rep_idx = w_idx;
                end
            end
        end
    end

    assign w_done       = r_pend | bus.mem_valid;
    assign w_rdata      = r_pend ? r_pend_data : bus.mem_rdata;
    assign w_retire     = (r_state == S_REQ) && w_done && !r_squash;
    // An in-flight store is always committed, so only a load can be squashed.
    assign w_squash_now = bus.flush && (r_state == S_REQ) && !r_squash && !w_done &&
                          !w_is_store[r_head];
    assign w_pop_head   = w_retire || w_squash_now;
    assign w_cdb_fire   = w_retire && !w_is_store[r_head] && !bus.flush;
    assign w_new_head   = w_pop_head ? r_head + c_ptr_one : r_head;
    assign w_disp_ok    = bus.disp_en && !bus.flush && (r_count != c_depth);
    assign w_nh         = r_head + c_ptr_one;
    // Eligible stores are committed and therefore survive a simultaneous flush.
    assign w_nh_ok      = (r_count > c_cnt_one) && w_elig[w_nh] &&
                          (!bus.flush || w_is_store[w_nh]);
    assign w_issue_idle = (r_state == S_IDLE) && (r_count != '0) && w_elig[r_head] &&
                          (!bus.flush || w_is_store[r_head]);
    assign w_iss_idx    = (r_state == S_IDLE) ? r_head : w_nh;
    assign w_rs1_fwd    = bus.cdb_in_valid && (bus.cdb_in_tag == bus.disp_rs1_tag);
    assign w_rs2_fwd    = bus.cdb_in_valid && (bus.cdb_in_tag == bus.disp_rs2_tag);

    // Commit is applied before the flush so the committed store is kept.
    always_comb begin
        w_comm_next = r_committed;
        if (bus.commit_store && w_commit_hit) begin
            w_comm_next[w_commit_idx] = 1'b1;
        end
        w_n_comm = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && w_comm_next[i] && !(w_pop_head && (c_ptr_w'(i) == r_head))) begin
                w_n_comm = w_n_comm + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]      <= '0;
                r_imm[i]     <= '0;
                r_rs1_val[i] <= '0;
                r_rs2_val[i] <= '0;
                r_rs1_tag[i] <= '0;
                r_rs2_tag[i] <= '0;
                r_dest[i]    <= '0;
                r_addr[i]    <= '0;
            end
            r_rs1_rdy      <= '0;
            r_rs2_rdy      <= '0;
            r_addr_rdy     <= '0;
            r_committed    <= '0;
            r_reported     <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_state        <= S_IDLE;
            r_squash       <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_data    <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_len      <= '0;
            r_mem_wdata    <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_tag      <= '0;
            r_cdb_data     <= '0;
            r_st_rdy_valid <= 1'b0;
            r_st_rdy_tag   <= '0;
        end else if (!bus.rdy) begin
            // Frozen; a completion is remembered and applied once rdy returns.
            if ((r_state == S_REQ) && bus.mem_valid) begin
                r_pend      <= 1'b1;
                r_pend_data <= bus.mem_rdata;
            end
        end else begin
            r_pend         <= 1'b0;
            r_cdb_valid    <= 1'b0;
            r_st_rdy_valid <= 1'b0;

            for (int i = 0; i < DEPTH; i++) begin
                if (!r_rs1_rdy[i] && bus.cdb_in_valid && (r_rs1_tag[i] == bus.cdb_in_tag)) begin
                    r_rs1_rdy[i] <= 1'b1;
                    r_rs1_val[i] <= bus.cdb_in_data;
                end
                if (!r_rs2_rdy[i] && bus.cdb_in_valid && (r_rs2_tag[i] == bus.cdb_in_tag)) begin
                    r_rs2_rdy[i] <= 1'b1;
                    r_rs2_val[i] <= bus.cdb_in_data;
                end
                if (r_rs1_rdy[i] && !r_addr_rdy[i]) begin
                    r_addr[i]     <= ADDR_W'(r_rs1_val[i] + r_imm[i]);
                    r_addr_rdy[i] <= 1'b1;
                end
            end

            if (w_rep_hit && !bus.flush) begin
                r_st_rdy_valid        <= 1'b1;
                r_st_rdy_tag          <= r_dest[w_rep_idx];
                r_reported[w_rep_idx] <= 1'b1;
            end

            r_committed <= w_comm_next;

            // Written last so a fresh entry overrides the per-entry updates above.
            if (w_disp_ok) begin
                r_op[r_tail]        <= bus.disp_op;
                r_imm[r_tail]       <= bus.disp_imm;
                r_rs1_rdy[r_tail]   <= bus.disp_rs1_rdy | w_rs1_fwd;
                r_rs1_val[r_tail]   <= bus.disp_rs1_rdy ? bus.disp_rs1_val : bus.cdb_in_data;
                r_rs1_tag[r_tail]   <= bus.disp_rs1_tag;
                r_rs2_rdy[r_tail]   <= bus.disp_rs2_rdy | w_rs2_fwd;
                r_rs2_val[r_tail]   <= bus.disp_rs2_rdy ? bus.disp_rs2_val : bus.cdb_in_data;
                r_rs2_tag[r_tail]   <= bus.disp_rs2_tag;
                r_dest[r_tail]      <= bus.disp_dest_tag;
                r_addr_rdy[r_tail]  <= 1'b0;
                r_committed[r_tail] <= 1'b0;
                r_reported[r_tail]  <= 1'b0;
            end

            if (bus.flush) begin
                r_head  <= w_new_head;
                r_tail  <= w_new_head + w_n_comm[c_ptr_w-1:0];
                r_count <= w_n_comm;
            end else begin
                r_head <= w_new_head;
                if (w_disp_ok) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_disp_ok && !w_retire) begin
                    r_count <= r_count + c_cnt_one;
                end else if (!w_disp_ok && w_retire) begin
                    r_count <= r_count - c_cnt_one;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue_idle) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    if (w_done) begin
                        r_squash <= 1'b0;
                        if (w_cdb_fire) begin
                            r_cdb_valid <= 1'b1;
                            r_cdb_tag   <= r_dest[r_head];
                            r_cdb_data  <= f_load(r_op[r_head][2:0], w_rdata);
                        end
                        if (r_squash || !w_nh_ok) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else if (w_squash_now) begin
                        r_squash <= 1'b1;
                    end
                end
            endcase

            // Launch from head when idle, or back-to-back from the next entry.
            if (w_issue_idle || ((r_state == S_REQ) && w_retire && w_nh_ok)) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_is_store[w_iss_idx];
                r_mem_addr  <= r_addr[w_iss_idx];
                r_mem_len   <= f_len(r_op[w_iss_idx][1:0]);
                r_mem_wdata <= f_wdata(r_op[w_iss_idx][1:0], r_rs2_val[w_iss_idx]);
            end
        end
    end

    assign bus.lsq_full     = (r_count >= (c_depth - c_cnt_one));
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_len      = r_mem_len;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_tag      = r_cdb_tag;
    assign bus.cdb_data     = r_cdb_data;
    assign bus.st_rdy_valid = r_st_rdy_valid;
    assign bus.st_rdy_tag   = r_st_rdy_tag;
endmodule
`default_nettype wire

// File: tb/tb_load_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_queue
// Purpose  : Directed self-checking bench for load_store_queue (DEPTH=8):
//            load issue/latency, load extension, pending store wake-up and
//            commit, full/wrap, flush with in-flight load, stall, and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    load_store_queue_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) bus ();

    load_store_queue #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [31:0] imm,
                            input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                            input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag,
                            input logic [3:0] dest);
        bus.disp_en       = 1'b1;
        bus.disp_op       = op;
        bus.disp_imm      = imm;
        bus.disp_rs1_rdy  = r1rdy;
        bus.disp_rs1_val  = r1val;
        bus.disp_rs1_tag  = r1tag;
        bus.disp_rs2_rdy  = r2rdy;
        bus.disp_rs2_val  = r2val;
        bus.disp_rs2_tag  = r2tag;
        bus.disp_dest_tag = dest;
        step();
        bus.disp_en = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 20 && bus.mem_req !== 1'b1; k++) step();
        chk(tag, bus.mem_req, 1);
    endtask

    task automatic complete(input logic [31:0] rdata);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_valid = 1'b0;
    endtask

    logic [3:0]  ext_op  [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
    logic [31:0] ext_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8F80, 32'h00008F80};

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rdy = 1'b1; bus.disp_en = 1'b0; bus.disp_op = '0; bus.disp_imm = '0;
        bus.disp_rs1_rdy = 1'b0; bus.disp_rs2_rdy = 1'b0; bus.disp_rs1_val = '0;
        bus.disp_rs2_val = '0; bus.disp_rs1_tag = '0; bus.disp_rs2_tag = '0;
        bus.disp_dest_tag = '0; bus.cdb_in_valid = 1'b0; bus.cdb_in_tag = '0;
        bus.cdb_in_data = '0; bus.commit_store = 1'b0; bus.flush = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_rdata = '0;

        // Reset state
        step(); step();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_cdb_valid", bus.cdb_valid, 0);
        chk("rst_st_rdy", bus.st_rdy_valid, 0);
        chk("rst_full", bus.lsq_full, 0);
        rst = 1'b1;
        step();

        // Single LW: request two edges after dispatch
        dispatch(4'b0010, 32'd4, 1, 32'h100, 0, 1, 0, 0, 4'd5);
        chk("lw_noreq_n", bus.mem_req, 0);
        step();
        chk("lw_noreq_n1", bus.mem_req, 0);
        step();
        chk("lw_req_n2", bus.mem_req, 1);
        chk("lw_addr", bus.mem_addr, 32'h104);
        chk("lw_len", bus.mem_len, 4);
        chk("lw_we", bus.mem_we, 0);
        step();
        chk("lw_req_hold", bus.mem_req, 1);
        complete(32'hDEADBEEF);
        chk("lw_cdb_valid", bus.cdb_valid, 1);
        chk("lw_cdb_tag", bus.cdb_tag, 5);
        chk("lw_cdb_data", bus.cdb_data, 32'hDEADBEEF);
        chk("lw_req_drop", bus.mem_req, 0);
        step();
        chk("lw_cdb_pulse", bus.cdb_valid, 0);

        // Byte/half extension
        for (int i = 0; i < 4; i++) begin
            dispatch(ext_op[i], 32'd0, 1, 32'h200, 0, 1, 0, 0, 4'(i));
            wait_req("ext_req");
            chk("ext_len", bus.mem_len, (i < 2) ? 1 : 2);
            complete(32'h00008F80);
            chk("ext_data", bus.cdb_data, ext_exp[i]);
            chk("ext_tag", bus.cdb_tag, i);
        end

        // SW with rs2 pending on tag 3
        dispatch(4'b1010, 32'd0, 1, 32'h240, 0, 0, 0, 4'd3, 4'd7);
        step(); step();
        chk("sw_no_strdy", bus.st_rdy_valid, 0);
        bus.cdb_in_valid = 1'b1; bus.cdb_in_tag = 4'd3; bus.cdb_in_data = 32'h12345678;
        step();
        bus.cdb_in_valid = 1'b0;
        step();
        chk("sw_strdy", bus.st_rdy_valid, 1);
        chk("sw_strdy_tag", bus.st_rdy_tag, 7);
        step();
        chk("sw_strdy_pulse", bus.st_rdy_valid, 0);
        step(); step();
        chk("sw_no_req_uncommitted", bus.mem_req, 0);
        bus.commit_store = 1'b1;
        step();
        bus.commit_store = 1'b0;
        step();
        chk("sw_req", bus.mem_req, 1);
        chk("sw_we", bus.mem_we, 1);
        chk("sw_len", bus.mem_len, 4);
        chk("sw_wdata", bus.mem_wdata, 32'h12345678);
        chk("sw_addr", bus.mem_addr, 32'h240);
        complete(32'h0);
        chk("sw_no_cdb", bus.cdb_valid, 0);
        chk("sw_req_drop", bus.mem_req, 0);

        // Two fill/drain passes with wrap
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 7; k++) begin
                if (k == 6) chk("fill_not_full", bus.lsq_full, 0);
                dispatch(4'b0010, 32'(k * 4), 0, 0, 4'd9, 1, 0, 0, 4'(k));
            end
            chk("fill_full", bus.lsq_full, 1);
            chk("fill_count", dut.r_count, 7);
            bus.cdb_in_valid = 1'b1; bus.cdb_in_tag = 4'd9; bus.cdb_in_data = 32'h1000;
            step();
            bus.cdb_in_valid = 1'b0;
            for (int k = 0; k < 7; k++) begin
                wait_req("drain_req");
                chk("drain_addr", bus.mem_addr, 32'h1000 + 32'(k * 4));
                complete(32'hA0 + 32'(k));
                chk("drain_tag", bus.cdb_tag, k);
                chk("drain_data", bus.cdb_data, 32'hA0 + 32'(k));
            end
            chk("drain_count", dut.r_count, 0);
            chk("drain_req_off", bus.mem_req, 0);
        end

        // Committed SB, two loads, flush while load 1 is in flight
        dispatch(4'b1000, 32'd1, 1, 32'h300, 0, 1, 32'hABCD12EF, 0, 4'd1);
        bus.commit_store = 1'b1;
        step();
        bus.commit_store = 1'b0;
        dispatch(4'b0010, 32'd0, 1, 32'h400, 0, 1, 0, 0, 4'd2);
        dispatch(4'b0010, 32'd0, 1, 32'h500, 0, 1, 0, 0, 4'd3);
        wait_req("fl_sb_req");
        chk("fl_sb_we", bus.mem_we, 1);
        chk("fl_sb_len", bus.mem_len, 1);
        chk("fl_sb_addr", bus.mem_addr, 32'h301);
        chk("fl_sb_wdata", bus.mem_wdata, 32'h000000EF);
        complete(32'h0);
        chk("fl_ld1_req", bus.mem_req, 1);
        chk("fl_ld1_addr", bus.mem_addr, 32'h400);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl_count", dut.r_count, 0);
        chk("fl_req_kept", bus.mem_req, 1);
        complete(32'h55);
        chk("fl_no_cdb", bus.cdb_valid, 0);
        chk("fl_req_drop", bus.mem_req, 0);
        step(); step(); step();
        chk("fl_no_ld2", bus.mem_req, 0);
        chk("fl_no_cdb2", bus.cdb_valid, 0);
        chk("fl_count_end", dut.r_count, 0);

        // mem_valid during stall is applied when rdy returns
        dispatch(4'b0010, 32'd0, 1, 32'h600, 0, 1, 0, 0, 4'd4);
        wait_req("stall_req");
        bus.rdy = 1'b0;
        complete(32'hCAFEF00D);
        step();
        chk("stall_no_cdb", bus.cdb_valid, 0);
        chk("stall_req_held", bus.mem_req, 1);
        bus.rdy = 1'b1;
        step();
        chk("stall_cdb", bus.cdb_valid, 1);
        chk("stall_cdb_data", bus.cdb_data, 32'hCAFEF00D);
        chk("stall_req_drop", bus.mem_req, 0);

        // Asynchronous reset in the middle of a request
        dispatch(4'b0010, 32'd0, 1, 32'h700, 0, 1, 0, 0, 4'd6);
        wait_req("rst_mid_req");
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_req", bus.mem_req, 0);
        chk("rst_async_count", dut.r_count, 0);
        chk("rst_async_addr", bus.mem_addr, 0);
        complete(32'h77);
        rst = 1'b1;
        step();
        chk("rst_no_cdb", bus.cdb_valid, 0);
        chk("rst_no_req", bus.mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
